// File: rtl/margin_min_select.sv
// Per-sample top1-top2 margin over a stream of class scores.
// Tracks the smallest margin and its sample index across one batch.
module margin_min_select #(
  parameter  int DATA_W    = 16,
  parameter  int N_CLASSES = 8,
  parameter  int N_SAMPLES = 1024,
  localparam int IDX_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              margin_valid,
  output logic [DATA_W-1:0] margin_out,
  output logic [IDX_W-1:0]  margin_idx,
  output logic              done,
  output logic [DATA_W-1:0] min_margin,
  output logic [IDX_W-1:0]  min_idx
);
  localparam int CLS_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(N_CLASSES - 1);
  localparam logic [IDX_W-1:0] SMP_LAST = IDX_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  logic [CLS_W-1:0]  r_cls;
  logic [IDX_W-1:0]  r_smp;
  logic [DATA_W-1:0] r_top1, r_top2;
  logic [DATA_W-1:0] w_top1, w_top2;
  logic              r_margin_valid, r_done;
  logic [DATA_W-1:0] r_margin_out, r_min_margin;
  logic [IDX_W-1:0]  r_margin_idx, r_min_idx;
  logic              w_acc;

  assign w_acc = s_valid & s_ready;

  // Running top-2; the first beat of a sample restarts the pair.
  always_comb begin
    w_top1 = r_top1;
    w_top2 = r_top2;
    if (r_cls == '0) begin
      w_top1 = s_data;
      w_top2 = '0;
    end else if (s_data > r_top1) begin
      w_top2 = r_top1;
      w_top1 = s_data;
    end else if (s_data > r_top2) begin
      w_top2 = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cls          <= '0;
      r_smp          <= '0;
      r_top1         <= '0;
      r_top2         <= '0;
      r_margin_valid <= 1'b0;
      r_margin_out   <= '0;
      r_margin_idx   <= '0;
      r_done         <= 1'b0;
      r_min_margin   <= '1;
      r_min_idx      <= '0;
    end else begin
      r_margin_valid <= 1'b0;
      r_done         <= 1'b0;
      // Sample 0 always loads; strict compare keeps the earlier index on ties.
      if (r_margin_valid && ((r_margin_out < r_min_margin) || (r_margin_idx == '0))) begin
        r_min_margin <= r_margin_out;
        r_min_idx    <= r_margin_idx;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_state      <= S_RUN;
          r_cls        <= '0;
          r_smp        <= '0;
          r_min_margin <= '1;
        end
        S_RUN: if (w_acc) begin
          r_top1 <= w_top1;
          r_top2 <= w_top2;
          if (r_cls == CLS_LAST) begin
            r_cls          <= '0;
            r_margin_out   <= w_top1 - w_top2;
            r_margin_idx   <= r_smp;
            r_margin_valid <= 1'b1;
            if (r_smp == SMP_LAST) r_state <= S_FLUSH;
            else                   r_smp   <= r_smp + IDX_W'(1);
          end else begin
            r_cls <= r_cls + CLS_W'(1);
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready      = (r_state == S_RUN);
  assign busy         = (r_state != S_IDLE);
  assign margin_valid = r_margin_valid;
  assign margin_out   = r_margin_out;
  assign margin_idx   = r_margin_idx;
  assign done         = r_done;
  assign min_margin   = r_min_margin;
  assign min_idx      = r_min_idx;
endmodule

// File: tb/tb_margin_min_select.sv
// Scoreboard bench for margin_min_select (N_CLASSES=4, N_SAMPLES=4).
module tb_margin_min_select;
  localparam int DW = 16, NC = 4, NS = 4, IW = 2;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, busy, margin_valid, done;
  logic [DW-1:0] margin_out, min_margin;
  logic [IW-1:0] margin_idx, min_idx;

  margin_min_select #(.DATA_W(DW), .N_CLASSES(NC), .N_SAMPLES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .busy(busy), .margin_valid(margin_valid), .margin_out(margin_out),
    .margin_idx(margin_idx), .done(done), .min_margin(min_margin), .min_idx(min_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  typedef struct { int m; int idx; int cyc; } exp_t;
  exp_t mq[$], dq[$];

  // Independent reference: largest value, then largest of the rest.
  function automatic int ref_margin(input int v0, v1, v2, v3);
    int v[4];
    int bi, m2;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    bi = 0;
    for (int i = 1; i < 4; i++) if (v[i] > v[bi]) bi = i;
    m2 = 0;
    for (int i = 0; i < 4; i++) if (i != bi && v[i] > m2) m2 = v[i];
    return v[bi] - m2;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (margin_valid === 1'b1) begin
        if (mq.size() == 0) chk("mv_spurious", 1, 0);
        else begin
          exp_t e;
          e = mq.pop_front();
          chk("margin_out", margin_out, e.m);
          chk("margin_idx", margin_idx, e.idx);
          chk("mv_latency", cyc, e.cyc);
          if (e.idx == NS - 1) chk("ready_flush", s_ready, 0);
        end
      end
      if (done === 1'b1) begin
        if (dq.size() == 0) chk("done_spurious", 1, 0);
        else begin
          exp_t e;
          e = dq.pop_front();
          chk("min_margin", min_margin, e.m);
          chk("min_idx", min_idx, e.idx);
          chk("done_latency", cyc, e.cyc);
          chk("ready_done", s_ready, 0);
          chk("busy_done", busy, 1);
        end
      end
    end
  end

  int cur[16];
  int bmin, bidx;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Sends beats [0:nbeats) of cur; stall inserts an idle cycle before each beat.
  task automatic run_batch(input int nbeats, input bit stall, input bit mid_start);
    int tcyc, k;
    bit acc;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_run", busy, 1);
    bmin = 0; bidx = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (stall) begin s_valid = 1'b0; tick(); end
      s_valid = 1'b1; s_data = DW'(cur[b]);
      if (mid_start && b == 5) start = 1'b1;
      k = 0;
      do begin acc = s_ready; tcyc = cyc; tick(); start = 1'b0; k++; end
      while (!acc && k < 20);
      if (!acc) chk("beat_timeout", 0, 1);
      if (b % NC == NC - 1) begin
        int s, m;
        s = b / NC;
        m = ref_margin(cur[b-3], cur[b-2], cur[b-1], cur[b]);
        mq.push_back('{m: m, idx: s, cyc: tcyc + 1});
        if (s == 0 || m < bmin) begin bmin = m; bidx = s; end
        if (s == NS - 1) dq.push_back('{m: bmin, idx: bidx, cyc: tcyc + 2});
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((mq.size() != 0 || dq.size() != 0) && k < 20) begin tick(); k++; end
    if (mq.size() != 0 || dq.size() != 0) chk("drain_timeout", 0, 1);
    tick();
  endtask

  task automatic load_batch4();
    cur = '{10,30,5,0, 7,0,0,0, 20,13,1,2, 30,0,0,0};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mv"}, margin_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mout"}, margin_out, 0);
    chk({tag, "_midx"}, margin_idx, 0);
    chk({tag, "_minidx"}, min_idx, 0);
    chk({tag, "_minm"}, min_margin, 16'hFFFF);
  endtask

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    // Idle after reset: nothing moves.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ready", s_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_minm", min_margin, 16'hFFFF);
    end
    chk_reset_vals("rst");

    // Margins 20, 0 (tie), 100, 0 -> min 0 at the earlier index 1.
    cur = '{10,50,30,20, 40,40,5,1, 100,0,0,0, 3,3,3,3};
    run_batch(16, 1'b0, 1'b0);
    wait_drain();
    chk("held_minm", min_margin, 0);
    chk("held_minidx", min_idx, 1);
    chk("idle_after", busy, 0);

    // Margins 20,7,7,30 back-to-back.
    load_batch4();
    run_batch(16, 1'b0, 1'b0);
    wait_drain();

    // Same batch with stalls and a start pulse during RUN.
    load_batch4();
    run_batch(16, 1'b1, 1'b1);
    wait_drain();

    // Abort after 6 beats with a one-cycle reset.
    load_batch4();
    run_batch(6, 1'b0, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mq.delete(); dq.delete();
    chk_reset_vals("abort");
    tick();
    load_batch4();
    run_batch(16, 1'b0, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
